// File: rtl/soc_top.sv
// LED/UART board SoC: six LEDs driven by a free-running counter XORed with the
// last UART byte received. Define SOC_ECHO_EN to build the UART echo transmitter.
module soc_top #(
  parameter int CLK_FREQ = 54000000,
  parameter int BAUD     = 115200,
  parameter int LED_DIV  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic [5:0] leds
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BW           = $clog2(CLKS_PER_BIT + 1);
  localparam int DW           = $clog2(LED_DIV);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic [1:0]    sync_reg;
  logic          rx_sync;
  rx_state_t     rx_state_reg;
  logic [BW-1:0] rx_cnt_reg;
  logic [BW-1:0] rx_limit;
  logic          rx_tick;
  logic          rx_done;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic [7:0]    rx_byte_reg;
  logic [DW-1:0] div_reg;
  logic [5:0]    cnt6_reg;

  // rxd is asynchronous; nothing downstream looks at it before two flops.
  always_ff @(posedge clk) begin
    if (rst_n) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], rxd};
  end
  assign rx_sync = sync_reg[1];

  assign rx_limit = (rx_state_reg == RX_START) ? BW'(HALF_BIT - 1) : BW'(CLKS_PER_BIT - 1);
  assign rx_tick  = (rx_cnt_reg == rx_limit);
  assign rx_done  = (rx_state_reg == RX_STOP) && rx_tick && rx_sync;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_byte_reg  <= '0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          rx_cnt_reg <= '0;
          if (!rx_sync) rx_state_reg <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + BW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt_reg <= '0;
            // A low stop bit is a framing error: keep the old byte and wait out the break.
            if (rx_sync) begin
              rx_byte_reg  <= rx_shift_reg;
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_state_reg <= RX_WAIT;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + BW'(1);
          end
        end
        RX_WAIT: begin
          rx_cnt_reg <= '0;
          if (rx_sync) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_reg  <= '0;
      cnt6_reg <= '0;
      leds     <= '0;
    end else begin
      if (div_reg == DW'(LED_DIV - 1)) begin
        div_reg  <= '0;
        cnt6_reg <= cnt6_reg + 6'd1;
      end else begin
        div_reg <= div_reg + DW'(1);
      end
      leds <= cnt6_reg ^ rx_byte_reg[5:0];
    end
  end

`ifdef SOC_ECHO_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state_reg;
  logic          rx_valid_reg;
  logic          buf_full_reg;
  logic [7:0]    buf_data_reg;
  logic [7:0]    tx_shift_reg;
  logic [BW-1:0] tx_cnt_reg;
  logic [2:0]    tx_bit_reg;
  logic          txd_reg;
  logic          tx_take;
  logic          tx_tick;

  assign tx_take = (tx_state_reg == TX_IDLE) && buf_full_reg;
  assign tx_tick = (tx_cnt_reg == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst_n) rx_valid_reg <= 1'b0;
    else       rx_valid_reg <= rx_done;
  end

  // A byte arriving just as the transmitter empties the buffer refills it at once.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      buf_full_reg <= 1'b0;
      buf_data_reg <= '0;
    end else if (rx_valid_reg && (!buf_full_reg || tx_take)) begin
      buf_full_reg <= 1'b1;
      buf_data_reg <= rx_byte_reg;
    end else if (tx_take) begin
      buf_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          txd_reg    <= 1'b1;
          tx_cnt_reg <= '0;
          if (buf_full_reg) begin
            tx_shift_reg <= buf_data_reg;
            txd_reg      <= 1'b0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + BW'(1);
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              txd_reg      <= 1'b1;
              tx_state_reg <= TX_STOP;
            end else begin
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + BW'(1);
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + BW'(1);
          end
        end
      endcase
    end
  end

  assign txd = txd_reg;
`else
  // Without the echo path only the low six received bits reach the LEDs.
  logic unused_rx_bits;
  assign unused_rx_bits = ^rx_byte_reg[7:6];
  assign txd = 1'b1;
`endif

endmodule

// File: tb/tb_soc_top.sv
// Directed self-checking bench for soc_top: reset, LED counting, break line,
// echo, framing error, back-to-back bytes and reset in the middle of an echo.
module tb_soc_top;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int LED_DIV  = 8;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       txd;
  logic [5:0] leds;

  int         vectors;
  int         miscompares;
  int         cyc;
  logic [7:0] rx_model;

  soc_top #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .LED_DIV (LED_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .txd  (txd),
    .leds (leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising edges since reset was last released.
  always @(posedge clk) begin
    if (rst_n) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // leds after edge k show cnt6 from edge k-1: floor((k-1)/LED_DIV) mod 64, XOR last good byte.
  function automatic logic [5:0] exp_leds();
    int steps;
    steps = (cyc - 1) / LED_DIV;
    return 6'(steps % 64) ^ rx_model[5:0];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    $display("rx send byte %02h stop=%b", b, stop_bit);
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic watch_idle(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== 1'b1) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("FAIL %s: txd=%b at cycle %0d, required 1", name, txd, i);
      end
    end
  endtask

  task automatic expect_tx(input logic [7:0] b, input string name);
`ifdef SOC_ECHO_EN
    logic [9:0] frame;
    int n;
    frame = {1'b1, b, 1'b0};
    n = 0;
    while (txd !== 1'b0 && n < 30 * CPB) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start: txd=%b after %0d cycles, required 0", name, txd, n);
    end else begin
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < CPB; c++) begin
          if (c == 0 || c == CPB / 2 || c == CPB - 1) begin
            vectors++;
            if (txd !== frame[i]) begin
              miscompares++;
              $display("FAIL %s bit%0d cyc%0d: txd=%b required %b", name, i, c, txd, frame[i]);
            end
          end
          if (!(i == 9 && c == CPB - 1)) @(negedge clk);
        end
      end
    end
    $display("tx echo byte %02h checked (%s)", b, name);
`else
    watch_idle(12 * CPB, name);
    $display("tx idle checked for byte %02h (%s)", b, name);
`endif
  endtask

  task automatic test_reset();
    rxd      = 1'b1;
    rst_n    = 1'b1;
    rx_model = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors += 2;
      if (leds !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_leds: leds=%b required 000000", leds);
      end
      if (txd !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_txd: txd=%b required 1", txd);
      end
    end
    rst_n = 1'b0;
    repeat (LED_DIV) @(negedge clk);
    vectors++;
    if (leds !== 6'd0) begin
      miscompares++;
      $display("FAIL count_at_div: leds=%b required 000000", leds);
    end
    @(negedge clk);
    vectors++;
    if (leds !== 6'd1) begin
      miscompares++;
      $display("FAIL count_at_div_plus1: leds=%b required 000001", leds);
    end
    repeat (LED_DIV - 1) @(negedge clk);
    vectors++;
    if (leds !== 6'd1) begin
      miscompares++;
      $display("FAIL count_at_2div: leds=%b required 000001", leds);
    end
    @(negedge clk);
    vectors++;
    if (leds !== 6'd2) begin
      miscompares++;
      $display("FAIL count_at_2div_plus1: leds=%b required 000010", leds);
    end
    $display("reset and count sequence done");
  endtask

  task automatic test_break();
    int bad;
    bad = 0;
    rxd   = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n    = 1'b0;
    rx_model = 8'h00;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      vectors += 2;
      if (txd !== 1'b1) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("FAIL break_txd: txd=%b required 1", txd);
      end
      if (leds !== exp_leds()) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("FAIL break_leds: leds=%b required %b", leds, exp_leds());
      end
    end
    // 599 / 8 = 74, which wrapped past 63 to 10.
    vectors++;
    if (leds !== 6'd10) begin
      miscompares++;
      $display("FAIL break_wrap: leds=%b required 001010", leds);
    end
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    $display("break line held 600 cycles");
  endtask

  task automatic test_echo();
    fork
      send_byte(8'h55, 1'b1);
      expect_tx(8'h55, "echo_55");
    join
    rx_model = 8'h55;
    @(negedge clk);
    vectors++;
    if (leds !== exp_leds()) begin
      miscompares++;
      $display("FAIL echo_leds: leds=%b required %b", leds, exp_leds());
    end
  endtask

  task automatic test_framing();
    fork
      begin
        send_byte(8'hA3, 1'b0);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
      end
      watch_idle(15 * CPB, "frame_err_no_echo");
    join
    vectors++;
    if (leds !== exp_leds()) begin
      miscompares++;
      $display("FAIL frame_err_leds: leds=%b required %b", leds, exp_leds());
    end
    fork
      send_byte(8'h0F, 1'b1);
      expect_tx(8'h0F, "echo_0f");
    join
    rx_model = 8'h0F;
    @(negedge clk);
    vectors++;
    if (leds !== exp_leds()) begin
      miscompares++;
      $display("FAIL after_frame_err_leds: leds=%b required %b", leds, exp_leds());
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
      end
      begin
        expect_tx(8'h01, "b2b_01");
        expect_tx(8'h02, "b2b_02");
        expect_tx(8'h03, "b2b_03");
      end
    join
    rx_model = 8'h03;
    @(negedge clk);
    vectors++;
    if (leds !== exp_leds()) begin
      miscompares++;
      $display("FAIL b2b_leds: leds=%b required %b", leds, exp_leds());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic mid_exp;
`ifdef SOC_ECHO_EN
    mid_exp = 1'b0;
`else
    mid_exp = 1'b1;
`endif
    // Echo of C3 starts ~156 cycles after the start edge; 245 lands mid data bit 4 (a 0).
    fork
      send_byte(8'hC3, 1'b1);
      repeat (245) @(negedge clk);
    join
    vectors++;
    if (txd !== mid_exp) begin
      miscompares++;
      $display("FAIL mid_frame_txd: txd=%b required %b", txd, mid_exp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_txd: txd=%b required 1", txd);
    end
    if (leds !== 6'b000000) begin
      miscompares++;
      $display("FAIL mid_reset_leds: leds=%b required 000000", leds);
    end
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    rx_model = 8'h00;
    watch_idle(12 * CPB, "no_residual_tx");
    vectors++;
    if (leds !== exp_leds()) begin
      miscompares++;
      $display("FAIL post_reset_leds: leds=%b required %b", leds, exp_leds());
    end
    $display("reset mid-frame sequence done");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_break();
    test_echo();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
